multiplicar_seq: RTL and testbench



---
 rtl/multiplicar_seq_if.sv | 22 ++
 rtl/multiplicar_seq.sv | 98 +++++++++
 tb/tb_multiplicar_seq.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/multiplicar_seq_if.sv
// Handshake and operand/result bundle for the sequential Q-format multiplier.
interface multiplicar_seq_if #(
    parameter int unsigned WIDTH = 20
);
    logic             iniciar;
    logic [WIDTH-1:0] multiplicando;
    logic [WIDTH-1:0] multiplicador;
    logic [WIDTH-1:0] produto;
    logic             overflow;
    logic             ocupado;
    logic             pronto;

    modport master (
        output iniciar, multiplicando, multiplicador,
        input  produto, overflow, ocupado, pronto
    );

    modport slave (
        input  iniciar, multiplicando, multiplicador,
        output produto, overflow, ocupado, pronto
    );
endinterface

// File: rtl/multiplicar_seq.sv
// Sequential unsigned fixed-point shift-add multiplier, one multiplier bit per clock.
// Companion to the dividir divider; same Q(WIDTH-FRAC).FRAC operand format.
module multiplicar_seq #(
    parameter int unsigned WIDTH = 20,
    parameter int unsigned FRAC  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    multiplicar_seq_if.slave  bus
);
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_sum;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               load;
    logic               last;
    logic               ocupado_c;
    logic               pronto_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        ocupado_c = 1'b0;
        pronto_c  = 1'b0;
        last      = (cnt == CW'(WIDTH - 1));
        case (state)
            IDLE: begin
                if (bus.iniciar) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                ocupado_c = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                pronto_c = 1'b1;
                if (bus.iniciar) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Shifting the multiplicand one place per iteration is the same as
    // adding it shifted left by the iteration count.
    always_comb begin
        acc_sum = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc          <= '0;
            mcand        <= '0;
            mplier       <= '0;
            cnt          <= '0;
            bus.produto  <= '0;
            bus.overflow <= 1'b0;
        end else if (load) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, bus.multiplicando};
            mplier <= bus.multiplicador;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (last) begin
                bus.produto  <= acc_sum[FRAC+WIDTH-1:FRAC];
                bus.overflow <= |acc_sum[2*WIDTH-1:FRAC+WIDTH];
            end
        end
    end

    assign bus.ocupado = ocupado_c;
    assign bus.pronto  = pronto_c;
endmodule

// File: tb/tb_multiplicar_seq.sv
// Bench for multiplicar_seq: arithmetic/timing reference model checked every cycle,
// plus directed operations with hand-computed results.
module tb_multiplicar_seq;
    localparam int unsigned WIDTH = 20;
    localparam int unsigned FRAC  = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multiplicar_seq_if #(.WIDTH(WIDTH)) bus ();

    multiplicar_seq #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference product: full-precision integer multiply, then drop FRAC bits.
    function automatic logic [WIDTH:0] ref_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [63:0] full;
        full = 64'(a) * 64'(b);
        return {((full >> (FRAC + WIDTH)) != 64'd0), WIDTH'(full >> FRAC)};
    endfunction

    int               m_left = 0;
    logic             m_done = 1'b0;
    logic [WIDTH-1:0] m_prod = '0;
    logic             m_ovf  = 1'b0;
    logic [WIDTH:0]   m_pend = '0;

    // Timing model: WIDTH busy cycles after a start, then a single done cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_prod <= '0;
            m_ovf  <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
            if (m_left == 1) begin
                m_prod <= m_pend[WIDTH-1:0];
                m_ovf  <= m_pend[WIDTH];
            end
        end else begin
            m_done <= 1'b0;
            if (bus.iniciar) begin
                m_left <= WIDTH;
                m_pend <= ref_mul(bus.multiplicando, bus.multiplicador);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ocupado", 64'(bus.ocupado), 64'(m_left > 0));
            check("pronto", 64'(bus.pronto), 64'(m_done));
            check("produto", 64'(bus.produto), 64'(m_prod));
            check("overflow", 64'(bus.overflow), 64'(m_ovf));
        end
    end

    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] ep, input logic eo, input bit disturb);
        int k = 0;
        int lat = -1;
        int pulses = 0;
        @(negedge clk);
        bus.multiplicando = a;
        bus.multiplicador = b;
        bus.iniciar       = 1'b1;
        while (k < 30) begin
            @(negedge clk);
            k++;
            if (k == 1) bus.iniciar = 1'b0;
            if (disturb && k == 5) begin
                bus.iniciar       = 1'b1;
                bus.multiplicando = '1;
                bus.multiplicador = '1;
            end
            if (disturb && k == 6) bus.iniciar = 1'b0;
            if (bus.pronto) begin
                if (lat < 0) lat = k;
                pulses++;
            end
        end
        check({name, "_latency"}, 64'(lat), 64'd21);
        check({name, "_pulses"}, 64'(pulses), 64'd1);
        check({name, "_produto"}, 64'(bus.produto), 64'(ep));
        check({name, "_overflow"}, 64'(bus.overflow), 64'(eo));
        check({name, "_model"}, 64'(m_prod), 64'(ep));
    endtask

    initial begin
        int seen;
        int k;
        int n;
        int p [3];

        bus.iniciar       = 1'b0;
        bus.multiplicando = '0;
        bus.multiplicador = '0;
        repeat (3) @(negedge clk);
        check("rst_produto", 64'(bus.produto), 64'd0);
        check("rst_overflow", 64'(bus.overflow), 64'd0);
        check("rst_ocupado", 64'(bus.ocupado), 64'd0);
        check("rst_pronto", 64'(bus.pronto), 64'd0);
        rst_n = 1'b1;

        // Abort mid-run: no pronto may follow.
        @(negedge clk);
        bus.multiplicando = 20'h05600;
        bus.multiplicador = 20'h07000;
        bus.iniciar       = 1'b1;
        @(negedge clk);
        bus.iniciar = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", 64'(bus.ocupado), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort_async_ocupado", 64'(bus.ocupado), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.pronto) seen++;
        end
        check("abort_pronto_count", 64'(seen), 64'd0);
        check("abort_produto", 64'(bus.produto), 64'd0);
        check("abort_ocupado", 64'(bus.ocupado), 64'd0);

        run_op("basic",  20'h05600, 20'h07000, 20'h25A00, 1'b0, 1'b0);
        run_op("trip",   20'h0C000, 20'h07000, 20'h54000, 1'b0, 1'b0);
        run_op("ovf",    20'h10000, 20'h10000, 20'h00000, 1'b1, 1'b0);
        run_op("trunc",  20'h00001, 20'h00001, 20'h00000, 1'b0, 1'b0);
        run_op("ignore", 20'h02000, 20'h03000, 20'h06000, 1'b0, 1'b1);

        // Back-to-back with iniciar held high.
        @(negedge clk);
        bus.multiplicando = 20'h01800;
        bus.multiplicador = 20'h02000;
        bus.iniciar       = 1'b1;
        n = 0;
        p = '{-100, -100, -100};
        for (k = 1; k <= 63; k++) begin
            @(negedge clk);
            if (bus.pronto && n < 3) begin
                p[n] = k;
                n++;
            end
        end
        bus.iniciar = 1'b0;
        check("b2b_pulses", 64'(n), 64'd3);
        check("b2b_first", 64'(p[0]), 64'd21);
        check("b2b_gap1", 64'(p[1] - p[0]), 64'd21);
        check("b2b_gap2", 64'(p[2] - p[1]), 64'd21);
        check("b2b_produto", 64'(bus.produto), 64'h03000);
        repeat (5) @(negedge clk);
        check("b2b_idle", 64'(bus.ocupado), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
